// File: rtl/fetch_prefetcher.sv
// Sequential instruction prefetch queue: fetches 16-bit words into a small FIFO, supports redirect
// (flush) and a sticky memory-error halt. Define PREFETCH_STATS_EN for fetched/dropped counters.
module fetch_prefetcher #(
  parameter int                    ADDR_WIDTH = 16,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  input  logic                  mem_error,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic                  cpu_valid,
  input  logic                  cpu_take,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_addr,
  output logic                  fetch_err
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]           stat_fetched,
  output logic [15:0]           stat_dropped
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] redir_q, redir_d;
  logic [DATA_WIDTH-1:0] cpu_data_q, cpu_data_d;
  logic [ADDR_WIDTH-1:0] cpu_addr_q, cpu_addr_d;
  logic                  cpu_valid_q, cpu_valid_d;
  logic                  fetch_err_q, fetch_err_d;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         remain;
  logic                  push, pop;

  logic [DATA_WIDTH-1:0] fifo_q [DEPTH];

  always_comb begin
    // Flush wins over both the cpu pop and any response landing in the same cycle.
    pop    = cpu_take && (count_q != '0) && !flush;
    push   = (state_q == S_REQ) && mem_ready && !mem_error && !flush;
    remain = count_q - CW'(pop);

    count_d     = flush ? '0 : (count_q + CW'(push) - CW'(pop));
    head_d      = flush ? '0 : (pop  ? head_q + PW'(1) : head_q);
    tail_d      = flush ? '0 : (push ? tail_q + PW'(1) : tail_q);
    cpu_valid_d = (count_d != '0);
    cpu_addr_d  = flush ? flush_addr : (pop ? cpu_addr_q + ADDR_WIDTH'(1) : cpu_addr_q);

    // The head register shadows the FIFO slot at the next head, bypassing a push into an empty queue.
    cpu_data_d = cpu_data_q;
    if (!flush) begin
      if (remain == '0) begin
        if (push) cpu_data_d = mem_data;
      end else begin
        cpu_data_d = fifo_q[head_d];
      end
    end

    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    redir_d     = redir_q;
    fetch_err_d = fetch_err_q;

    case (state_q)
      S_IDLE: begin
        if (flush) begin
          mem_addr_d = flush_addr;
        end else if (count_q < CW'(DEPTH)) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
        end
      end
      S_REQ: begin
        if (flush) begin
          if (mem_ready || mem_error) begin
            state_d    = S_IDLE;
            mem_req_d  = 1'b0;
            mem_addr_d = flush_addr;
          end else begin
            state_d = S_DRAIN;
            redir_d = flush_addr;
          end
        end else if (mem_error) begin
          state_d     = S_HALT;
          mem_req_d   = 1'b0;
          fetch_err_d = 1'b1;
        end else if (mem_ready) begin
          mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
          if (count_d >= CW'(DEPTH)) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        if (flush) redir_d = flush_addr;
        if (mem_ready || mem_error) begin
          state_d    = S_REQ;
          mem_addr_d = flush ? flush_addr : redir_q;
        end
      end
      S_HALT: begin
        if (flush) begin
          state_d     = S_IDLE;
          fetch_err_d = 1'b0;
          mem_addr_d  = flush_addr;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= RESET_ADDR;
      redir_q     <= RESET_ADDR;
      cpu_data_q  <= '0;
      cpu_addr_q  <= RESET_ADDR;
      cpu_valid_q <= 1'b0;
      fetch_err_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      redir_q     <= redir_d;
      cpu_data_q  <= cpu_data_d;
      cpu_addr_q  <= cpu_addr_d;
      cpu_valid_q <= cpu_valid_d;
      fetch_err_q <= fetch_err_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[tail_q] <= mem_data;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign cpu_data  = cpu_data_q;
  assign cpu_addr  = cpu_addr_q;
  assign cpu_valid = cpu_valid_q;
  assign fetch_err = fetch_err_q;

`ifdef PREFETCH_STATS_EN
  logic [15:0] fetched_q, dropped_q;
  logic        drop_ev;

  // A response is discarded when it arrives during DRAIN or collides with a flush in REQ.
  assign drop_ev = ((state_q == S_REQ) && flush && mem_ready && !mem_error) ||
                   ((state_q == S_DRAIN) && (mem_ready || mem_error));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      if (push && (fetched_q != 16'hFFFF))    fetched_q <= fetched_q + 16'd1;
      if (drop_ev && (dropped_q != 16'hFFFF)) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_dropped = dropped_q;
`endif

endmodule

// File: tb/tb_fetch_prefetcher.sv
// Bench for fetch_prefetcher: queue-level reference model checked every cycle plus directed scenarios.
`timescale 1ns/1ps
module tb_fetch_prefetcher;
  localparam int DEPTH = 4;
  localparam int LAT   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic        mem_error = 1'b0;
  logic [15:0] cpu_data;
  logic [15:0] cpu_addr;
  logic        cpu_valid;
  logic        cpu_take = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_addr = '0;
  logic        fetch_err;

  fetch_prefetcher #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(DEPTH), .RESET_ADDR(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_ready(mem_ready), .mem_error(mem_error),
    .cpu_data(cpu_data), .cpu_addr(cpu_addr), .cpu_valid(cpu_valid), .cpu_take(cpu_take),
    .flush(flush), .flush_addr(flush_addr), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    n_total++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h2000;
      16'h0001: return 16'hFF00;
      16'h0002: return 16'h2100;
      16'h0003: return 16'h00FF;
      16'h0004: return 16'h1010;
      16'hFFFF: return 16'hABCD;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  // Memory controller: answers each request LAT cycles after it is first seen.
  int          wait_cnt = 0;
  logic        err_en = 1'b0;
  logic [15:0] err_addr = '0;
  always @(negedge clk) begin
    mem_ready = 1'b0;
    mem_error = 1'b0;
    if (rst || !mem_req) begin
      wait_cnt = 0;
    end else if (wait_cnt == LAT - 1) begin
      wait_cnt = 0;
      if (err_en && mem_addr == err_addr) mem_error = 1'b1;
      else begin
        mem_ready = 1'b1;
        mem_data  = mem_word(mem_addr);
      end
    end else begin
      wait_cnt++;
    end
  end

  // Reference model: a queue of (address, word) pairs the cpu must see, next expected fetch
  // address, expected head address, halt flag, and whether the next response is to be discarded.
  typedef struct packed { logic [15:0] a; logic [15:0] d; } ent_t;
  ent_t        mq[$];
  logic [15:0] m_head = '0;
  logic [15:0] m_fetch = '0;
  logic        m_err = 1'b0;
  logic        m_drop = 1'b0;
  logic        snap_req = 1'b0;
  logic [15:0] snap_addr = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_head = 16'h0000; m_fetch = 16'h0000; m_err = 1'b0; m_drop = 1'b0;
    end else if (flush) begin
      if (snap_req) m_drop = !(mem_ready || mem_error);
      mq.delete();
      m_head = flush_addr; m_fetch = flush_addr; m_err = 1'b0;
    end else begin
      if (cpu_take && mq.size() > 0) begin
        $display("pop  addr=%h data=%h", mq[0].a, mq[0].d);
        m_head = mq[0].a + 16'd1;
        void'(mq.pop_front());
      end
      if (mem_ready || mem_error) begin
        if (m_drop) m_drop = 1'b0;
        else if (mem_error) m_err = 1'b1;
        else begin
          chk("fetch_addr", {16'h0, snap_addr}, {16'h0, m_fetch});
          mq.push_back({m_fetch, mem_data});
          m_fetch = m_fetch + 16'd1;
        end
      end
      if (mq.size() > DEPTH) timeout("fifo_overflow");
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("cpu_valid", {31'h0, cpu_valid}, {31'h0, mq.size() != 0});
      if (mq.size() != 0) chk("cpu_data", {16'h0, cpu_data}, {16'h0, mq[0].d});
      chk("cpu_addr", {16'h0, cpu_addr}, {16'h0, m_head});
      chk("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
      if (m_err) chk("halt_no_req", {31'h0, mem_req}, 32'h0);
    end
    snap_req  = mem_req;
    snap_addr = mem_addr;
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cpu_take = 1'b0; flush = 1'b0; err_en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_flush(input logic [15:0] a);
    flush = 1'b1; flush_addr = a;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (cpu_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) timeout(name);
  endtask

  logic [15:0] exp_a [5] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
  logic [15:0] exp_d [5] = '{16'h2000, 16'hFF00, 16'h2100, 16'h00FF, 16'h1010};
  logic [15:0] got_a [5];
  logic [15:0] got_d [5];

  initial begin
    bit ok;
    int n;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req",   {31'h0, mem_req},   32'h0);
    chk("rst_mem_addr",  {16'h0, mem_addr},  32'h0);
    chk("rst_cpu_valid", {31'h0, cpu_valid}, 32'h0);
    chk("rst_cpu_data",  {16'h0, cpu_data},  32'h0);
    chk("rst_fetch_err", {31'h0, fetch_err}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {31'h0, mem_req}, 32'h1);

    // 1: no consumer, queue fills and fetching stops
    repeat (40) @(negedge clk);
    chk("t1_mem_req",   {31'h0, mem_req},   32'h0);
    chk("t1_mem_addr",  {16'h0, mem_addr},  32'h0004);
    chk("t1_cpu_valid", {31'h0, cpu_valid}, 32'h1);
    chk("t1_cpu_data",  {16'h0, cpu_data},  32'h2000);
    chk("t1_cpu_addr",  {16'h0, cpu_addr},  32'h0000);

    // 2: consumer always taking sees every word once, in order
    do_reset();
    cpu_take = 1'b1;
    n = 0;
    for (int i = 0; i < 100 && n < 5; i++) begin
      @(negedge clk);
      if (cpu_valid) begin got_a[n] = cpu_addr; got_d[n] = cpu_data; n++; end
    end
    cpu_take = 1'b0;
    if (n < 5) timeout("t2_stream");
    for (int i = 0; i < n; i++) begin
      chk("t2_addr", {16'h0, got_a[i]}, {16'h0, exp_a[i]});
      chk("t2_data", {16'h0, got_d[i]}, {16'h0, exp_d[i]});
    end

    // 3: redirect to 0003 while the request for 0002 is outstanding
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 16'h0002) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("t3_req2");
    do_flush(16'h0003);
    chk("t3_valid_cleared", {31'h0, cpu_valid}, 32'h0);
    chk("t3_drain_addr",    {16'h0, mem_addr},  32'h0002);
    wait_valid("t3_refill", ok);
    chk("t3_cpu_addr", {16'h0, cpu_addr}, 32'h0003);
    chk("t3_cpu_data", {16'h0, cpu_data}, 32'h00FF);

    // 4: memory error on 0002, queued words still drain, flush recovers
    do_reset();
    err_en = 1'b1; err_addr = 16'h0002;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (fetch_err) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("t4_halt");
    chk("t4_mem_req", {31'h0, mem_req}, 32'h0);
    for (int i = 0; i < 2; i++) begin
      got_d[i] = cpu_data;
      cpu_take = 1'b1;
      @(negedge clk);
      cpu_take = 1'b0;
    end
    chk("t4_pop0", {16'h0, got_d[0]}, 32'h2000);
    chk("t4_pop1", {16'h0, got_d[1]}, 32'hFF00);
    repeat (3) @(negedge clk);
    chk("t4_empty",     {31'h0, cpu_valid}, 32'h0);
    chk("t4_err_stuck", {31'h0, fetch_err}, 32'h1);
    err_en = 1'b0;
    do_flush(16'h0000);
    chk("t4_err_clear", {31'h0, fetch_err}, 32'h0);
    wait_valid("t4_resume", ok);
    chk("t4_cpu_addr", {16'h0, cpu_addr}, 32'h0000);
    chk("t4_cpu_data", {16'h0, cpu_data}, 32'h2000);

    // 5: address wrap FFFF -> 0000
    do_flush(16'hFFFF);
    wait_valid("t5_first", ok);
    chk("t5_addr_ffff", {16'h0, cpu_addr}, 32'hFFFF);
    chk("t5_data_ffff", {16'h0, cpu_data}, 32'hABCD);
    cpu_take = 1'b1;
    @(negedge clk);
    cpu_take = 1'b0;
    wait_valid("t5_second", ok);
    chk("t5_addr_0000", {16'h0, cpu_addr}, 32'h0000);
    chk("t5_data_0000", {16'h0, cpu_data}, 32'h2000);

    // 6: asynchronous reset mid-request clears outputs before the next edge
    do_reset();
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_req && cpu_valid) begin ok = 1'b1; break; end
    end
    if (!ok) timeout("t6_busy");
    #2 rst = 1'b1;
    #1;
    chk("t6_mem_req",   {31'h0, mem_req},   32'h0);
    chk("t6_mem_addr",  {16'h0, mem_addr},  32'h0);
    chk("t6_cpu_valid", {31'h0, cpu_valid}, 32'h0);
    chk("t6_cpu_addr",  {16'h0, cpu_addr},  32'h0);
    chk("t6_cpu_data",  {16'h0, cpu_data},  32'h0);
    chk("t6_fetch_err", {31'h0, fetch_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
